uart_cmd_wrapper: RTL and testbench
===================================

Name: uart_cmd_wrapper

Overview:
Controller that sequences the UART receiver and transmitter datapaths for the host link. It assembles two received bytes, high byte first, into one 16-bit command for the command processor. It also schedules single-byte responses onto the transmitter with a one-deep pending slot. It sits between the UART rx/tx instances and the command processor.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between high-byte capture and low-byte arrival (used only with the optional feature).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver
rx_rdy  input  1  receiver byte valid (level, held until cleared)
clr_rx_rdy  output  1  combinational consume strobe to receiver
cmd  output  16  assembled command {high,low}
cmd_rdy  output  1  command valid (level)
clr_cmd_rdy  input  1  command processor has consumed cmd
cmd_err  output  1  one-cycle pulse on inter-byte timeout
resp  input  8  response byte to send
send_resp  input  1  one-cycle request to send resp
trmt  output  1  one-cycle start strobe to UART transmitter
tx_data  output  8  byte presented to transmitter
tx_done  input  1  transmitter finished byte (one-cycle pulse)
resp_sent  output  1  one-cycle pulse, mirrors tx_done of a scheduled byte
resp_busy  output  1  transmitter busy and pending slot full; send_resp ignored

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active-low. Reset: state=WAIT_HIGH, cmd=16'h0000, cmd_rdy=0, cmd_err=0, trmt=0, tx_data=8'h00, resp_sent=0, resp_busy=0, internal high-byte reg=0, tx_busy=0, pending empty, timeout counter=0.
- rx FSM states: WAIT_HIGH, WAIT_LOW.
- WAIT_HIGH & rx_rdy: capture rx_data into high reg; clr_rx_rdy=1 the same cycle; cmd_rdy cleared next edge (a new command has started); go to WAIT_LOW. cmd itself is unchanged.
- WAIT_LOW & rx_rdy: cmd<={high,rx_data} and cmd_rdy<=1 at the next edge; clr_rx_rdy=1 the same cycle; go to WAIT_HIGH.
- clr_rx_rdy is asserted only in the cycle a byte is consumed. It is never asserted while rx_rdy=0.
- cmd_rdy clears on clr_cmd_rdy. If clr_cmd_rdy coincides with completion of a new command, set wins: cmd_rdy=1 with the new cmd.
- Latency: cmd_rdy rises 1 cycle after the cycle in which the low byte is seen with rx_rdy.
- tx scheduler:
  - send_resp while tx_busy=0: trmt=1 and tx_data=resp at the next edge; tx_busy<=1.
  - send_resp while tx_busy=1 and pending empty: store resp in pending.
  - tx_done: resp_sent pulse next cycle. If pending is full, issue trmt with the pending byte at the same edge, keep tx_busy=1, and empty pending. Otherwise tx_busy<=0.
  - send_resp coincident with tx_done and pending empty: the new byte is issued directly via trmt.
- resp_busy = tx_busy & pending full. send_resp while resp_busy is dropped silently.
- tx_done while tx_busy=0 is ignored (no resp_sent).
- rx and tx paths are independent; simultaneous events on both are handled in the same cycle.

Optional Feature:
Macro UART_CMD_TIMEOUT_EN.
- Defined: counter clears on entry to WAIT_LOW and increments each cycle in WAIT_LOW. When the count reaches TIMEOUT_CYCLES-1 with no rx_rdy, the FSM returns to WAIT_HIGH, the high byte is discarded, and cmd_err pulses for 1 cycle. rx_rdy in that same cycle wins: the command completes and there is no error.
- Not defined: no counter is built; WAIT_LOW waits indefinitely; cmd_err is tied 0.

Decomposition:
- Package uart_wrap_pkg: rx state enum (WAIT_HIGH, WAIT_LOW) and the default TIMEOUT_CYCLES constant.
- One sub-module is natural: uart_resp_sched, containing the tx_busy flag, the pending slot, and the trmt/resp_sent generation.
- The rx FSM, cmd register and timeout stay in the top module.

Test Plan:
- rx bytes 8'hA5 then 8'h3C -> clr_rx_rdy pulses twice; cmd=16'hA53C; cmd_rdy=1 one cycle after the second byte; it stays high until clr_cmd_rdy, then drops next edge.
- cmd_rdy=1 (cmd=16'h1234); new high byte 8'h56 arrives -> cmd_rdy drops, cmd stays 16'h1234; low byte 8'h78 -> cmd=16'h5678, cmd_rdy=1.
- clr_cmd_rdy in the same cycle as completion of 16'hBEEF -> cmd_rdy=1, cmd=16'hBEEF.
- send_resp 8'hA5, then 8'h5A while busy, then 8'h11 while busy -> trmt issues 8'hA5; on tx_done, trmt issues 8'h5A; 8'h11 is dropped; resp_busy=1 after the second request; two resp_sent pulses total.
- UART_CMD_TIMEOUT_EN defined with TIMEOUT_CYCLES=16: high byte 8'hFF and no low byte -> cmd_err pulses 16 cycles after capture; next bytes 8'h01, 8'h02 give cmd=16'h0102.
- Reset asserted in WAIT_LOW with a byte pending in the tx slot -> all outputs return to their reset values asynchronously; after release, bytes 8'hC0, 8'hDE give cmd=16'hC0DE.

Source files
------------

// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared types and defaults for the UART command wrapper.
package uart_wrap_pkg;

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } rx_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Link bundle between the UART rx/tx side, the command processor and the wrapper.
// master: the surrounding environment; slave: the wrapper itself.
interface uart_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_err;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        resp_busy;

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, cmd_err, trmt, tx_data, resp_sent, resp_busy
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, cmd_err, trmt, tx_data, resp_sent, resp_busy
  );
endinterface

// File: rtl/uart_resp_sched.sv
// Response scheduler: one byte in flight on the transmitter plus a one-deep pending slot.
module uart_resp_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_resp,
  input  logic       i_sendResp,
  input  logic       i_txDone,
  output logic       o_trmt,
  output logic [7:0] o_txData,
  output logic       o_respSent,
  output logic       o_respBusy
);

  logic       r_txBusy;
  logic       r_pendFull;
  logic [7:0] r_pend;
  logic       r_trmt;
  logic [7:0] r_txData;
  logic       r_respSent;
  logic       w_doneEvt;

  // A tx_done with nothing in flight is stray and must not produce resp_sent.
  assign w_doneEvt = i_txDone & r_txBusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txBusy   <= 1'b0;
      r_pendFull <= 1'b0;
      r_pend     <= 8'h00;
      r_trmt     <= 1'b0;
      r_txData   <= 8'h00;
      r_respSent <= 1'b0;
    end else begin
      r_trmt     <= 1'b0;
      r_respSent <= w_doneEvt;
      if (w_doneEvt) begin
        if (r_pendFull) begin
          r_trmt     <= 1'b1;
          r_txData   <= r_pend;
          r_pendFull <= 1'b0;
        end else if (i_sendResp) begin
          r_trmt   <= 1'b1;
          r_txData <= i_resp;
        end else begin
          r_txBusy <= 1'b0;
        end
      end else if (i_sendResp) begin
        if (!r_txBusy) begin
          r_trmt   <= 1'b1;
          r_txData <= i_resp;
          r_txBusy <= 1'b1;
        end else if (!r_pendFull) begin
          r_pend     <= i_resp;
          r_pendFull <= 1'b1;
        end
      end
    end
  end

  assign o_trmt     = r_trmt;
  assign o_txData   = r_txData;
  assign o_respSent = r_respSent;
  assign o_respBusy = r_txBusy & r_pendFull;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two rx bytes (high first) into a 16-bit command and schedules tx responses.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_wrapper
  import uart_wrap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic       clk,
  input logic       rst_n,
  uart_cmd_if.slave bus
);

  rx_state_e   r_state;
  rx_state_e   w_nextState;
  logic [7:0]  r_high;
  logic [15:0] r_cmd;
  logic        r_cmdRdy;
  logic        w_clrRxRdy;
  logic        w_captureHigh;
  logic        w_complete;
  logic        w_timeout;
  logic        w_timeoutHit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmdErr;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cmdErr <= 1'b0;
    end else begin
      r_cmdErr <= w_timeoutHit;
      if (w_captureHigh)
        r_cnt <= '0;
      else if (r_state == WAIT_LOW)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.cmd_err = r_cmdErr;
`else
  logic w_unusedTimeoutCfg;
  assign w_unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout          = 1'b0;
  assign bus.cmd_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= WAIT_HIGH;
    else
      r_state <= w_nextState;
  end

  // A byte arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    w_nextState   = r_state;
    w_clrRxRdy    = 1'b0;
    w_captureHigh = 1'b0;
    w_complete    = 1'b0;
    w_timeoutHit  = 1'b0;
    case (r_state)
      WAIT_HIGH: begin
        if (bus.rx_rdy) begin
          w_clrRxRdy    = 1'b1;
          w_captureHigh = 1'b1;
          w_nextState   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (bus.rx_rdy) begin
          w_clrRxRdy  = 1'b1;
          w_complete  = 1'b1;
          w_nextState = WAIT_HIGH;
        end else if (w_timeout) begin
          w_timeoutHit = 1'b1;
          w_nextState  = WAIT_HIGH;
        end
      end
      default: w_nextState = WAIT_HIGH;
    endcase
  end

  // Completion beats a coincident clr_cmd_rdy so a fresh command is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high   <= 8'h00;
      r_cmd    <= 16'h0000;
      r_cmdRdy <= 1'b0;
    end else begin
      if (w_captureHigh)
        r_high <= bus.rx_data;
      else if (w_timeoutHit)
        r_high <= 8'h00;
      if (w_complete) begin
        r_cmd    <= {r_high, bus.rx_data};
        r_cmdRdy <= 1'b1;
      end else if (w_captureHigh || bus.clr_cmd_rdy) begin
        r_cmdRdy <= 1'b0;
      end
    end
  end

  assign bus.clr_rx_rdy = w_clrRxRdy;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmdRdy;

  uart_resp_sched u_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_resp     (bus.resp),
    .i_sendResp (bus.send_resp),
    .i_txDone   (bus.tx_done),
    .o_trmt     (bus.trmt),
    .o_txData   (bus.tx_data),
    .o_respSent (bus.resp_sent),
    .o_respBusy (bus.resp_busy)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed self-checking bench for uart_cmd_wrapper (TIMEOUT_CYCLES=16).
module tb_uart_cmd_wrapper;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;
  int   sentCount;

  uart_cmd_if bus ();

  uart_cmd_wrapper #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.resp_sent === 1'b1)
      sentCount++;
  end

  task automatic pushByte(input logic [7:0] b, output logic clrSeen);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    #1 clrSeen = bus.clr_rx_rdy;
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nCompared++;
    if ({bus.cmd, bus.cmd_rdy, bus.cmd_err, bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy} !== 29'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got cmd=%h rdy=%b err=%b trmt=%b txd=%h sent=%b busy=%b, want all zero",
               bus.cmd, bus.cmd_rdy, bus.cmd_err, bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (bus.clr_rx_rdy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_clr_rx_rdy: got %b want 0", bus.clr_rx_rdy);
    end
  endtask

  task automatic test_rx_basic();
    logic c1, c2;
    pushByte(8'hA5, c1);
    nCompared++;
    if (bus.cmd_rdy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_rdy_after_high: got %b want 0", bus.cmd_rdy);
    end
    pushByte(8'h3C, c2);
    nCompared++;
    if ({c1, c2} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL basic_clr_rx_rdy: got %b%b want 11", c1, c2);
    end
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hA53C) begin
      nMismatched++;
      $display("[TB] FAIL basic_cmd: got rdy=%b cmd=%h want rdy=1 cmd=a53c", bus.cmd_rdy, bus.cmd);
    end
    repeat (3) @(posedge clk);
    #1;
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.clr_rx_rdy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_hold: got rdy=%b clr=%b want rdy=1 clr=0", bus.cmd_rdy, bus.clr_rx_rdy);
    end
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 bus.clr_cmd_rdy = 1'b0;
    nCompared++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'hA53C) begin
      nMismatched++;
      $display("[TB] FAIL basic_consume: got rdy=%b cmd=%h want rdy=0 cmd=a53c", bus.cmd_rdy, bus.cmd);
    end
  endtask

  task automatic test_new_over_old();
    logic c;
    pushByte(8'h12, c);
    pushByte(8'h34, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h1234) begin
      nMismatched++;
      $display("[TB] FAIL over_first: got rdy=%b cmd=%h want rdy=1 cmd=1234", bus.cmd_rdy, bus.cmd);
    end
    pushByte(8'h56, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h1234) begin
      nMismatched++;
      $display("[TB] FAIL over_high_clears: got rdy=%b cmd=%h want rdy=0 cmd=1234", bus.cmd_rdy, bus.cmd);
    end
    pushByte(8'h78, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h5678) begin
      nMismatched++;
      $display("[TB] FAIL over_second: got rdy=%b cmd=%h want rdy=1 cmd=5678", bus.cmd_rdy, bus.cmd);
    end
  endtask

  task automatic test_clr_coincident();
    logic c;
    pushByte(8'hBE, c);
    @(negedge clk);
    bus.rx_data     = 8'hEF;
    bus.rx_rdy      = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hBEEF) begin
      nMismatched++;
      $display("[TB] FAIL coincident_set_wins: got rdy=%b cmd=%h want rdy=1 cmd=beef", bus.cmd_rdy, bus.cmd);
    end
  endtask

  task automatic test_tx_sched();
    int base;
    base = sentCount;
    @(negedge clk);
    bus.resp = 8'hA5; bus.send_resp = 1'b1;
    @(posedge clk);
    #1 bus.send_resp = 1'b0;
    nCompared++;
    if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hA5 || bus.resp_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tx_first: got trmt=%b txd=%h busy=%b want 1 a5 0", bus.trmt, bus.tx_data, bus.resp_busy);
    end
    @(negedge clk);
    bus.resp = 8'h5A; bus.send_resp = 1'b1;
    @(posedge clk);
    #1 bus.send_resp = 1'b0;
    nCompared++;
    if (bus.trmt !== 1'b0 || bus.resp_busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL tx_pending: got trmt=%b busy=%b want 0 1", bus.trmt, bus.resp_busy);
    end
    @(negedge clk);
    bus.resp = 8'h11; bus.send_resp = 1'b1;
    @(posedge clk);
    #1 bus.send_resp = 1'b0;
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    nCompared++;
    if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h5A || bus.resp_sent !== 1'b1 || bus.resp_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tx_drain_pending: got trmt=%b txd=%h sent=%b busy=%b want 1 5a 1 0",
               bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy);
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    nCompared++;
    if (bus.trmt !== 1'b0 || bus.resp_sent !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL tx_drop_third: got trmt=%b sent=%b want 0 1", bus.trmt, bus.resp_sent);
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    nCompared++;
    if (sentCount - base !== 2 || bus.resp_sent !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tx_sent_count: got %0d pulses sent=%b want 2 pulses sent=0", sentCount - base, bus.resp_sent);
    end
    // New request coinciding with tx_done and an empty slot goes straight out.
    bus.resp = 8'h77; bus.send_resp = 1'b1;
    @(posedge clk);
    #1 bus.send_resp = 1'b0;
    @(negedge clk);
    bus.resp = 8'h88; bus.send_resp = 1'b1; bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.send_resp = 1'b0; bus.tx_done = 1'b0;
    nCompared++;
    if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h88 || bus.resp_sent !== 1'b1 || bus.resp_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tx_coincident: got trmt=%b txd=%h sent=%b busy=%b want 1 88 1 0",
               bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy);
    end
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    nCompared++;
    if (bus.resp_sent !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tx_stray_done: got sent=%b want 0", bus.resp_sent);
    end
  endtask

  task automatic test_timeout();
    logic c;
    int   errAt;
    errAt = -1;
    pushByte(8'hFF, c);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.cmd_err === 1'b1 && errAt < 0)
        errAt = i;
    end
`ifdef UART_CMD_TIMEOUT_EN
    nCompared++;
    if (errAt !== 16) begin
      nMismatched++;
      $display("[TB] FAIL timeout_cycle: got err at %0d want 16", errAt);
    end
    pushByte(8'h01, c);
    pushByte(8'h02, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h0102 || bus.cmd_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL timeout_recover: got rdy=%b cmd=%h err=%b want 1 0102 0", bus.cmd_rdy, bus.cmd, bus.cmd_err);
    end
`else
    nCompared++;
    if (errAt !== -1) begin
      nMismatched++;
      $display("[TB] FAIL no_timeout_err: got err at %0d want never", errAt);
    end
    pushByte(8'h02, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hFF02) begin
      nMismatched++;
      $display("[TB] FAIL no_timeout_wait: got rdy=%b cmd=%h want 1 ff02", bus.cmd_rdy, bus.cmd);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    logic c;
    pushByte(8'hC0, c);
    @(negedge clk);
    bus.resp = 8'h33; bus.send_resp = 1'b1;
    @(posedge clk);
    #1 bus.resp = 8'h44;
    @(posedge clk);
    #1 bus.send_resp = 1'b0;
    nCompared++;
    if (bus.resp_busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midflight_pre_busy: got %b want 1", bus.resp_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({bus.cmd, bus.cmd_rdy, bus.cmd_err, bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy} !== 29'h0) begin
      nMismatched++;
      $display("[TB] FAIL midflight_async_reset: got cmd=%h rdy=%b err=%b trmt=%b txd=%h sent=%b busy=%b, want all zero",
               bus.cmd, bus.cmd_rdy, bus.cmd_err, bus.trmt, bus.tx_data, bus.resp_sent, bus.resp_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pushByte(8'hC0, c);
    pushByte(8'hDE, c);
    nCompared++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hC0DE || bus.resp_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midflight_after: got rdy=%b cmd=%h busy=%b want 1 c0de 0", bus.cmd_rdy, bus.cmd, bus.resp_busy);
    end
  endtask

  initial begin
    nCompared       = 0;
    nMismatched     = 0;
    sentCount       = 0;
    rst_n           = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
    $display("[TB] starting uart_cmd_wrapper bench");
    test_reset();
    test_rx_basic();
    test_new_over_old();
    test_clr_coincident();
    test_tx_sched();
    test_timeout();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
